vga_pattern_gen: RTL and testbench
==================================

Name: vga_pattern_gen

Overview:
- Sits directly downstream of the VGA sync/timing generator, in the same dot-clock domain.
- Consumes the raw active-low hsync/vsync pair and recovers the pixel and line position from sync edges.
- Produces data-enable, pixel coordinates and a selectable 24-bit RGB test pattern, with sync outputs re-aligned to the pixel data.
- Also reports whether the incoming frame timing is stable (locked).

Parameters:
H_SYNC, 96, hsync pulse width in dot clocks
H_BP, 48, horizontal back porch in dot clocks
H_ACTIVE, 640, visible pixels per line
V_SYNC, 2, vsync pulse width in lines
V_BP, 33, vertical back porch in lines
V_ACTIVE, 480, visible lines per frame
V_TOTAL, 525, expected lines per frame (used for lock)
BOX, 64, moving-box edge length in pixels

Ports:
clk  in  1  dot clock; the only clock
rst_n  in  1  asynchronous, active-low reset
hsync_in  in  1  active-low hsync from the timing generator
vsync_in  in  1  active-low vsync from the timing generator
mode  in  2  pattern select: 0 solid, 1 colour bars, 2 checkerboard, 3 moving box
solid_rgb  in  24  {R,G,B} colour for mode 0
hsync_out  out  1  hsync delayed 2 clocks
vsync_out  out  1  vsync delayed 2 clocks
de  out  1  data enable (active pixel)
x_val  out  10  pixel column 0..639; 0 when de=0
y_val  out  10  pixel row 0..479; 0 when de=0
red / green / blue  out  8 each  pixel colour; 0 when de=0
locked  out  1  frame timing stable

Behaviour:
- Reset (async, rst_n=0):
  - hsync_out=1, vsync_out=1; internal sync delay registers=1; previous-sync registers=1, so no false edge is seen on release.
  - de=0, x_val=0, y_val=0, rgb=0, locked=0.
  - h_cnt=v_cnt=1023, frame_cnt=0, box position (0,0), latched mode=0.
- Edge detection:
  - Falling edge = previous sample 1 and current input 0.
- Horizontal counter (h_cnt, 10 bit):
  - hsync falling edge -> h_cnt<=0; otherwise increment, saturating at 1023.
- Vertical counter (v_cnt, 10 bit):
  - vsync falling edge -> v_cnt<=0. This has priority over an hsync edge in the same cycle.
  - Otherwise, an hsync falling edge increments v_cnt, saturating at 1023.
- Frame start (vsync falling edge):
  - frame_cnt++ (16 bit, wraps).
  - mode and solid_rgb are latched; changes mid-frame are ignored until the next frame start.
  - Box position updates: bx+1 wraps 576->0, by+1 wraps 416->0.
  - Lock check:
    - If v_cnt==V_TOTAL-1, the match counter increments, saturating at 2; otherwise it clears to 0 and locked drops immediately.
    - locked=1 when the match counter reaches 2.
    - The first vsync edge after reset never counts as a match, because v_cnt=1023.
- Active region:
  - h_act: H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE (144..783).
  - v_act: V_SYNC+V_BP <= v_cnt < +V_ACTIVE (35..514).
  - de = h_act & v_act.
- Output register stage:
  - de, x_val=h_cnt-144, y_val=v_cnt-35 and RGB are all registered from the current counters.
- Latency:
  - The counters are one register stage and the outputs a second.
  - Input sync to hsync_out/vsync_out, and sync edge to the matching de/x/rgb, are both exactly 2 clocks.
- Blanking:
  - When de=0, x_val=y_val=0 and rgb=0.
- Patterns (when de=1):
  - 0: latched solid_rgb.
  - 1: 8 bars, each 80 px wide; bar=floor(x/80), built from a compare chain with no divider.
    - Colour order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - 2: x[5]^y[5] ? FFFFFF : 000000.
  - 3: white when bx<=x<bx+BOX and by<=y<by+BOX; else 0000FF.
- Missing syncs: the counters saturate at 1023, so de stays 0 and the output is black.
- Reset mid-frame: outputs blank until the next hsync/vsync edges rebuild position; locked requires 2 fresh good frames.

Decomposition:
- Shared package vga_pkg:
  - Timing constants (H_SYNC, H_BP, H_ACTIVE, V_SYNC, V_BP, V_ACTIVE, V_TOTAL).
  - Mode encodings.
  - 24-bit colour constants for the bar palette.
- Optional sub-module vga_sync_tracker (edge detect, h_cnt/v_cnt, frame_cnt, lock). Pattern muxing and the output registers stay in the top module.

Test Plan:
- Reset released mid-line, bench drives 800x525 timing (hsync low 96 clocks, vsync low 2 lines):
  - rgb=0 and de=0 until the first hsync edge after a vsync edge.
  - locked=0 after frame 1 and 1 after the second full 525-line frame.
- Mode 1, watch line y=0:
  - de rises exactly 146 clocks after the hsync_in fall, with x_val=0, rgb=FFFFFF.
  - x=80 -> FFFF00; x=639 -> 000000.
  - de falls after 640 pixels.
- Mode 2:
  - (x=31,y=0)=000000; (x=32,y=0)=FFFFFF; (x=32,y=32)=000000.
- Mode 3 across 3 frames:
  - Box origin goes (0,0), (1,1), (2,2).
  - Pixel (1,1) is white in frame 2, and pixel (0,0) is 0000FF in frame 2.
- Mode changed 0->1 at line 200 with solid_rgb=123456:
  - The rest of the frame stays 123456.
  - Bars start at the next vsync.
- Bench drops to 524 lines for one frame:
  - locked falls at that vsync edge.
  - It re-asserts after 2 further 525-line frames; hsync_out/vsync_out always equal the inputs delayed by 2 clocks.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants, mode/lock encodings and the colour-bar palette for
// the VGA pattern generator.
package vga_pkg;

  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_TOTAL  = 525;
  localparam int unsigned BOX      = 64;

  localparam int unsigned BAR_W = 80;
  localparam int unsigned CNT_W = 10;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [23:0]      rgb_t;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_BOX     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    LK_SEARCH = 2'd0,
    LK_ONE    = 2'd1,
    LK_LOCKED = 2'd2
  } lock_e;

  localparam rgb_t C_WHITE   = 24'hFFFFFF;
  localparam rgb_t C_YELLOW  = 24'hFFFF00;
  localparam rgb_t C_CYAN    = 24'h00FFFF;
  localparam rgb_t C_GREEN   = 24'h00FF00;
  localparam rgb_t C_MAGENTA = 24'hFF00FF;
  localparam rgb_t C_RED     = 24'hFF0000;
  localparam rgb_t C_BLUE    = 24'h0000FF;
  localparam rgb_t C_BLACK   = 24'h000000;

  // Bar index by compare chain; avoids a divide-by-80 in the pixel path.
  function automatic rgb_t bar_colour(input cnt_t x);
    if      (x < cnt_t'(1 * BAR_W)) return C_WHITE;
    else if (x < cnt_t'(2 * BAR_W)) return C_YELLOW;
    else if (x < cnt_t'(3 * BAR_W)) return C_CYAN;
    else if (x < cnt_t'(4 * BAR_W)) return C_GREEN;
    else if (x < cnt_t'(5 * BAR_W)) return C_MAGENTA;
    else if (x < cnt_t'(6 * BAR_W)) return C_RED;
    else if (x < cnt_t'(7 * BAR_W)) return C_BLUE;
    else                            return C_BLACK;
  endfunction

endpackage

// File: rtl/vga_sync_tracker.sv
// Recovers pixel/line position from raw sync falling edges, counts frames and
// tracks whether consecutive frames have the expected line count.
module vga_sync_tracker #(
  parameter int unsigned V_TOTAL = vga_pkg::V_TOTAL
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       frame_start,
  output logic       locked
);
  import vga_pkg::*;

  localparam cnt_t CNT_MAX   = '1;
  localparam cnt_t LAST_LINE = cnt_t'(V_TOTAL - 1);

  logic        hs_prev, vs_prev;
  logic        hs_fall, vs_fall;
  logic [15:0] frame_cnt;
  lock_e       lock_state, lock_next;

  assign hs_fall     = hs_prev & ~hsync_in;
  assign vs_fall     = vs_prev & ~vsync_in;
  assign frame_start = vs_fall;
  assign locked      = (lock_state == LK_LOCKED);

  // NOTE: non-blocking assignments so every register here samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_prev    <= 1'b1;
      vs_prev    <= 1'b1;
      h_cnt      <= CNT_MAX;
      v_cnt      <= CNT_MAX;
      frame_cnt  <= '0;
      lock_state <= LK_SEARCH;
    end else begin
      hs_prev    <= hsync_in;
      vs_prev    <= vsync_in;
      lock_state <= lock_next;

      if (hs_fall)
        h_cnt <= '0;
      else if (h_cnt != CNT_MAX)
        h_cnt <= h_cnt + 1'b1;

      // A frame start also resets the line count, winning over the hsync edge.
      if (vs_fall) begin
        v_cnt     <= '0;
        frame_cnt <= frame_cnt + 1'b1;
      end else if (hs_fall && v_cnt != CNT_MAX) begin
        v_cnt <= v_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: default first so no path leaves lock_next unassigned and infers a latch.
    lock_next = lock_state;
    if (vs_fall) begin
      if (v_cnt != LAST_LINE) begin
        lock_next = LK_SEARCH;
      end else begin
        case (lock_state)
          LK_SEARCH: lock_next = LK_ONE;
          default:   lock_next = LK_LOCKED;
        endcase
      end
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator driven by raw VGA syncs: position recovery, pattern
// selection, and a registered output stage aligned with delayed syncs.
module vga_pattern_gen #(
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_TOTAL  = vga_pkg::V_TOTAL,
  parameter int unsigned BOX      = vga_pkg::BOX
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        de,
  output logic [9:0]  x_val,
  output logic [9:0]  y_val,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        locked
);
  import vga_pkg::*;

  localparam cnt_t        H_START = cnt_t'(H_SYNC + H_BP);
  localparam cnt_t        H_END   = cnt_t'(H_SYNC + H_BP + H_ACTIVE);
  localparam cnt_t        V_START = cnt_t'(V_SYNC + V_BP);
  localparam cnt_t        V_END   = cnt_t'(V_SYNC + V_BP + V_ACTIVE);
  localparam cnt_t        BX_MAX  = cnt_t'(H_ACTIVE - BOX);
  localparam cnt_t        BY_MAX  = cnt_t'(V_ACTIVE - BOX);
  localparam logic [10:0] BOX_W   = 11'(BOX);

  cnt_t  h_cnt, v_cnt;
  logic  frame_start, trk_locked;
  logic  hs_d1, vs_d1;
  mode_e mode_q;
  rgb_t  solid_q;
  cnt_t  box_x, box_y;

  logic  active, in_box;
  cnt_t  x_c, y_c;
  rgb_t  pix;

  vga_sync_tracker #(
    .V_TOTAL (V_TOTAL)
  ) u_tracker (
    .clk         (clk),
    .rst_n       (rst_n),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .frame_start (frame_start),
    .locked      (trk_locked)
  );

  // Sync delay and per-frame settings; mode/colour only change at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_d1     <= 1'b1;
      vs_d1     <= 1'b1;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      mode_q    <= MODE_SOLID;
      solid_q   <= '0;
      box_x     <= '0;
      box_y     <= '0;
    end else begin
      hs_d1     <= hsync_in;
      vs_d1     <= vsync_in;
      hsync_out <= hs_d1;
      vsync_out <= vs_d1;
      if (frame_start) begin
        mode_q  <= mode_e'(mode);
        solid_q <= solid_rgb;
        box_x   <= (box_x == BX_MAX) ? '0 : box_x + 1'b1;
        box_y   <= (box_y == BY_MAX) ? '0 : box_y + 1'b1;
      end
    end
  end

  always_comb begin
    active = (h_cnt >= H_START) && (h_cnt < H_END) &&
             (v_cnt >= V_START) && (v_cnt < V_END);
    x_c    = h_cnt - H_START;
    y_c    = v_cnt - V_START;
    in_box = ({1'b0, x_c} >= {1'b0, box_x}) && ({1'b0, x_c} < {1'b0, box_x} + BOX_W) &&
             ({1'b0, y_c} >= {1'b0, box_y}) && ({1'b0, y_c} < {1'b0, box_y} + BOX_W);
    case (mode_q)
      MODE_SOLID:   pix = solid_q;
      MODE_BARS:    pix = bar_colour(x_c);
      MODE_CHECKER: pix = (x_c[5] ^ y_c[5]) ? C_WHITE : C_BLACK;
      default:      pix = in_box ? C_WHITE : C_BLUE;
    endcase
  end

  // Output stage: everything blanks to zero outside the active window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de                 <= 1'b0;
      x_val              <= '0;
      y_val              <= '0;
      {red, green, blue} <= '0;
      locked             <= 1'b0;
    end else begin
      de                 <= active;
      x_val              <= active ? x_c : '0;
      y_val              <= active ? y_c : '0;
      {red, green, blue} <= active ? pix : '0;
      locked             <= trk_locked;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomised bench for vga_pattern_gen with a reduced raster: a frame-level
// reference model fills a scoreboard that a negedge monitor drains.
module tb_vga_pattern_gen;

  localparam int HS   = 4;
  localparam int HBP  = 4;
  localparam int HACT = 176;
  localparam int HFP  = 4;
  localparam int HT   = HS + HBP + HACT + HFP;
  localparam int VS   = 2;
  localparam int VBP  = 2;
  localparam int VACT = 34;
  localparam int VFP  = 1;
  localparam int VT   = VS + VBP + VACT + VFP;
  localparam int BOXP = 16;
  localparam int SHORT_FRAME = 4;
  localparam int LAST_FRAME  = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [23:0] solid_rgb = 24'h0;
  logic        hsync_out, vsync_out, de, locked;
  logic [9:0]  x_val, y_val;
  logic [7:0]  red, green, blue;

  vga_pattern_gen #(
    .H_SYNC   (HS),
    .H_BP     (HBP),
    .H_ACTIVE (HACT),
    .V_SYNC   (VS),
    .V_BP     (VBP),
    .V_ACTIVE (VACT),
    .V_TOTAL  (VT),
    .BOX      (BOXP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .mode      (mode),
    .solid_rgb (solid_rgb),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .de        (de),
    .x_val     (x_val),
    .y_val     (y_val),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          hp;
    int          vp;
    logic [47:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [23:0] palette [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [23:0] ref_pixel(input logic [1:0] md, input logic [23:0] sol,
                                            input int x, input int y, input int bx, input int by);
    case (md)
      2'd0:    return sol;
      2'd1:    return palette[x / 80];
      2'd2:    return (((x / 32) % 2) != ((y / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
      default: return (x >= bx && x < bx + BOXP && y >= by && y < by + BOXP) ? 24'hFFFFFF : 24'h0000FF;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check($sformatf("pixel h=%0d v=%0d", e.hp, e.vp),
            64'({hsync_out, vsync_out, de, x_val, y_val, red, green, blue, locked}),
            64'(e.v));
    end
  end

  initial begin
    int          hp, vp, f, rel_hp, good, bx, by, vt_cur, vt_prev, x, y, w;
    logic        known_h, known_v, prev_hs, prev_vs, released, exp_de;
    logic [1:0]  lmode;
    logic [23:0] lsol, exp_rgb;

    hp = 0; vp = 10; f = 0; good = 0; bx = 0; by = 0;
    vt_cur = VT; vt_prev = VT;
    known_h = 1'b0; known_v = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1; released = 1'b0;
    lmode = 2'd0; lsol = 24'h0;
    rel_hp = int'($urandom_range(HT - 1, HS + 1));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", 64'({hsync_out, vsync_out, de, x_val, y_val, red, green, blue, locked}),
          64'({1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 24'd0, 1'b0}));

    while (!(f == LAST_FRAME && vp == VS + VBP + 4)) begin
      @(posedge clk);
      #1;
      if (hp == 0 && vp == 0) begin
        case (f)
          1, 5:    mode = 2'd1;
          2:       mode = 2'd2;
          3, 6:    mode = 2'd3;
          4:       begin mode = 2'd0; solid_rgb = 24'h123456; end
          default: begin mode = 2'($urandom_range(0, 3)); solid_rgb = 24'($urandom); end
        endcase
      end
      if (hp == 0 && vp == 20) begin
        mode      = (f == SHORT_FRAME) ? 2'd1 : 2'($urandom_range(0, 3));
        solid_rgb = 24'($urandom);
      end
      hsync_in = (hp >= HS);
      vsync_in = (vp >= VS);
      if (!released && f == 0 && vp == 12 && hp == rel_hp) begin
        rst_n    = 1'b1;
        released = 1'b1;
      end

      if (released) begin
        if (prev_hs && !hsync_in) known_h = 1'b1;
        if (prev_vs && !vsync_in) begin
          if (known_v && vt_prev == VT) good = (good < 2) ? good + 1 : 2;
          else                          good = 0;
          known_v = 1'b1;
          lmode   = mode;
          lsol    = solid_rgb;
          bx      = (bx == HACT - BOXP) ? 0 : bx + 1;
          by      = (by == VACT - BOXP) ? 0 : by + 1;
        end
        exp_de  = known_h && known_v &&
                  hp >= HS + HBP && hp < HS + HBP + HACT &&
                  vp >= VS + VBP && vp < VS + VBP + VACT;
        x       = exp_de ? hp - (HS + HBP) : 0;
        y       = exp_de ? vp - (VS + VBP) : 0;
        exp_rgb = exp_de ? ref_pixel(lmode, lsol, x, y, bx, by) : 24'h0;
        sb.push_back('{due: cyc + 2, hp: hp, vp: vp,
                       v: {hsync_in, vsync_in, exp_de, 10'(x), 10'(y), exp_rgb, (good == 2)}});
      end
      prev_hs = hsync_in;
      prev_vs = vsync_in;

      hp++;
      if (hp == HT) begin
        hp = 0;
        vp++;
        if (vp == vt_cur) begin
          vp      = 0;
          f++;
          vt_prev = vt_cur;
          vt_cur  = (f == SHORT_FRAME) ? VT - 1 : VT;
        end
      end
    end

    w = 0;
    while (sb.size() > 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    check("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
